example_driver: RTL and testbench
=================================

Name: example_driver

Overview:
- Initiator-side sequencer for the generated `example` FSM block; replaces the hand-written stimulus sequence with synthesizable logic.
- Accepts {offset, target} commands over a valid/ready request port and drives start/offset/target into `example`.
- Waits for the done rising edge, then captures `variable` and `state`.
- Returns the captured values over a valid/ready result port; a watchdog flags commands that never complete.

Parameters:
- START_CYCLES, 2, cycles ex_start is held high per command (1..15).
- TIMEOUT, 1000, max cycles from start deassertion to done rise (1..65535).
- OFF_W, 2, offset width.
- DATA_W, 8, target/variable width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  command available.
- req_ready  out  1  driver can accept a command; high only in IDLE.
- req_offset  in  OFF_W  command offset.
- req_target  in  DATA_W  command target.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_variable  out  DATA_W  captured ex_variable.
- res_state  out  3  captured ex_state.
- res_timeout  out  1  result is a timeout, not a completion.
- busy  out  1  high in any state other than IDLE.
- ex_start  out  1  start to example.
- ex_offset  out  OFF_W  offset to example; held stable for the whole command.
- ex_target  out  DATA_W  target to example; held stable for the whole command.
- ex_done  in  1  done from example.
- ex_state  in  3  state from example.
- ex_variable  in  DATA_W  variable from example.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - All outputs and registers are 0, except req_ready=1.
  - Includes ex_start, res_valid, res_timeout, busy, and the counters.
- FSM states: IDLE, START, WAIT, RESULT.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_offset/req_target into ex_offset/ex_target, set ex_start=1, load start_cnt=START_CYCLES-1, go to START.
- START:
  - ex_start=1.
  - Each cycle: if start_cnt==0 then ex_start<=0, clear timer, go to WAIT; else decrement start_cnt.
  - ex_start is therefore high for exactly START_CYCLES clocks.
- WAIT:
  - done_q is the 1-cycle delayed ex_done; done_q is cleared on entry to START.
  - Rise = ex_done & ~done_q.
  - A done level already high on entry is not a rise.
  - On rise: capture ex_variable→res_variable and ex_state→res_state in the same cycle; res_timeout<=0; res_valid<=1; go to RESULT.
  - Otherwise: timer increments by 1, saturating at TIMEOUT.
- RESULT:
  - res_valid=1; res_variable, res_state and res_timeout are held stable.
  - On res_ready: res_valid<=0, go to IDLE.
  - req_ready returns to 1 the cycle after the handshake, so there is 1 dead cycle between commands.
- Latency, with START_CYCLES=2 and done rising k cycles after ex_start falls: res_valid rises k+1 cycles after ex_start falls.
- Simultaneous req_valid and res_ready in RESULT: the request is not accepted until IDLE.
- ex_offset/ex_target change only on request acceptance. They keep their last value afterwards, including after timeout.
- Reset mid-command:
  - Immediate return to IDLE with ex_start=0 and any pending result discarded.
  - A later ex_done rise with no command in flight is ignored.

Optional Feature:
- Macro: EXAMPLE_DRIVER_TIMEOUT_EN.
- Defined:
  - In WAIT, when timer==TIMEOUT-1 with no rise, go to RESULT with res_timeout=1.
  - res_variable and res_state carry the current ex_variable and ex_state.
- Undefined:
  - Timer logic is absent, WAIT waits indefinitely, and res_timeout is tied to 0.
  - TIMEOUT is ignored.

Test Plan:
1. Reset release, no traffic: after reset goes 0→1, check req_ready=1, busy=0, ex_start=0, res_valid=0.
2. Single command offset=2, target=120, START_CYCLES=2; model example raises done 5 cycles after start falls with variable=122, state=3.
   - ex_start is high for exactly 2 cycles.
   - res_valid=1 with res_variable=122, res_state=3, res_timeout=0.
   - ex_offset=2 and ex_target=120 hold throughout.
3. Back-pressure: hold res_ready=0 for 10 cycles in RESULT.
   - res_valid and the captured values stay constant; req_ready=0.
   - Release res_ready: IDLE is reached the next cycle.
4. Stale done: ex_done already 1 when WAIT is entered, then falls and rises again later.
   - Only the second rise produces a result.
5. Timeout (macro defined, TIMEOUT=20): ex_done stays 0.
   - res_valid=1 with res_timeout=1 exactly 20 cycles after ex_start falls.
   - After res_ready, the next command is accepted normally.
6. Reset mid-WAIT: drive reset=0 for 1 cycle.
   - Outputs clear asynchronously and a later ex_done rise produces no result.
   - The next command completes normally.

Source files
------------

// File: rtl/example_driver_if.sv
// Command/result/example bundle for example_driver; the driver uses the slave
// modport, while the command source and the example block sit on master.
interface example_driver_if #(
   parameter int OFF_W  = 2,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [OFF_W-1:0]  req_offset;
   logic [DATA_W-1:0] req_target;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_variable;
   logic [2:0]        res_state;
   logic              res_timeout;
   logic              busy;
   logic              ex_start;
   logic [OFF_W-1:0]  ex_offset;
   logic [DATA_W-1:0] ex_target;
   logic              ex_done;
   logic [2:0]        ex_state;
   logic [DATA_W-1:0] ex_variable;

   modport slave (
      input  req_valid, req_offset, req_target, res_ready,
             ex_done, ex_state, ex_variable,
      output req_ready, res_valid, res_variable, res_state, res_timeout,
             busy, ex_start, ex_offset, ex_target
   );

   modport master (
      output req_valid, req_offset, req_target, res_ready,
             ex_done, ex_state, ex_variable,
      input  req_ready, res_valid, res_variable, res_state, res_timeout,
             busy, ex_start, ex_offset, ex_target
   );
endinterface

// File: rtl/example_driver.sv
// Sequencer that runs one {offset,target} command through `example` and returns
// the captured result. Define EXAMPLE_DRIVER_TIMEOUT_EN to enable the watchdog.
module example_driver #(
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 1000,
   parameter int OFF_W        = 2,
   parameter int DATA_W       = 8
) (
   input  logic           clk,
   input  logic           reset,
   example_driver_if.slave bus
);
   typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

   localparam logic [3:0] START_LOAD = 4'(START_CYCLES - 1);

   if (START_CYCLES < 1 || START_CYCLES > 15) begin : g_bad_start
      $error("example_driver: START_CYCLES must be 1..15");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("example_driver: TIMEOUT must be 1..65535");
   end

   state_t            state_reg, state_next;
   logic [3:0]        start_cnt_reg;
   logic              done_reg;
   logic              rise;
   logic              timeout_hit;
   logic [OFF_W-1:0]  ex_offset_reg;
   logic [DATA_W-1:0] ex_target_reg;
   logic [DATA_W-1:0] res_variable_reg;
   logic [2:0]        res_state_reg;

   // A done level that was already high before WAIT is not a rise.
   assign rise = bus.ex_done & ~done_reg;

`ifdef EXAMPLE_DRIVER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] TIMEOUT_MAX  = 16'(TIMEOUT);

   logic [15:0] timer_reg;
   logic        res_timeout_reg;

   assign timeout_hit     = (timer_reg == TIMEOUT_LAST) & ~rise;
   assign bus.res_timeout = res_timeout_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_reg <= '0;
      end else if (state_reg == START && start_cnt_reg == 4'd0) begin
         timer_reg <= '0;
      end else if (state_reg == WAIT && timer_reg != TIMEOUT_MAX) begin
         timer_reg <= timer_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_timeout_reg <= 1'b0;
      end else if (state_reg == WAIT && (rise || timeout_hit)) begin
         res_timeout_reg <= timeout_hit;
      end
   end
`else
   assign timeout_hit     = 1'b0;
   assign bus.res_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.req_valid)                 state_next = START;
         START:   if (start_cnt_reg == 4'd0)         state_next = WAIT;
         WAIT:    if (rise || timeout_hit)           state_next = RESULT;
         RESULT:  if (bus.res_ready)                 state_next = IDLE;
         default:                                    state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_reg == IDLE);
      bus.busy      = (state_reg != IDLE);
      bus.ex_start  = (state_reg == START);
      bus.res_valid = (state_reg == RESULT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_cnt_reg    <= '0;
         done_reg         <= 1'b0;
         ex_offset_reg    <= '0;
         ex_target_reg    <= '0;
         res_variable_reg <= '0;
         res_state_reg    <= '0;
      end else begin
         done_reg <= bus.ex_done;
         case (state_reg)
            IDLE: if (bus.req_valid) begin
               ex_offset_reg <= bus.req_offset;
               ex_target_reg <= bus.req_target;
               start_cnt_reg <= START_LOAD;
               done_reg      <= 1'b0;
            end
            START: if (start_cnt_reg != 4'd0) begin
               start_cnt_reg <= start_cnt_reg - 4'd1;
            end
            WAIT: if (rise || timeout_hit) begin
               res_variable_reg <= bus.ex_variable;
               res_state_reg    <= bus.ex_state;
            end
            default: ;
         endcase
      end
   end

   assign bus.ex_offset    = ex_offset_reg;
   assign bus.ex_target    = ex_target_reg;
   assign bus.res_variable = res_variable_reg;
   assign bus.res_state    = res_state_reg;
endmodule

// File: tb/tb_example_driver.sv
// Directed bench for example_driver: the initial block plays both the command
// source and the `example` block, with hand-computed expected results.
module tb_example_driver;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   example_driver_if #(.OFF_W(2), .DATA_W(8)) bus ();

   example_driver #(
      .START_CYCLES(2),
      .TIMEOUT     (20),
      .OFF_W       (2),
      .DATA_W      (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a command and return right after the edge where ex_start falls.
   task automatic send_cmd(input logic [1:0] off, input logic [7:0] tgt);
      int n;
      bus.req_valid  = 1'b1;
      bus.req_offset = off;
      bus.req_target = tgt;
      step();
      bus.req_valid  = 1'b0;
      bus.req_offset = 2'd0;
      bus.req_target = 8'd0;
      check("ex_offset_latched", 32'(bus.ex_offset), 32'(off));
      check("ex_target_latched", 32'(bus.ex_target), 32'(tgt));
      n = 0;
      while (bus.ex_start === 1'b1 && n < 20) begin
         n++;
         step();
      end
      check("start_len", n, 2);
   endtask

   // Done rises k cycles after ex_start fell; result must appear one cycle later.
   task automatic finish_cmd(input int k, input logic [7:0] var_v, input logic [2:0] st_v);
      repeat (k) step();
      check("res_valid_before_rise", 32'(bus.res_valid), 0);
      bus.ex_done     = 1'b1;
      bus.ex_variable = var_v;
      bus.ex_state    = st_v;
      step();
      check("res_valid_after_rise", 32'(bus.res_valid), 1);
      check("res_variable", 32'(bus.res_variable), 32'(var_v));
      check("res_state", 32'(bus.res_state), 32'(st_v));
      check("res_timeout_clear", 32'(bus.res_timeout), 0);
   endtask

   task automatic accept_result();
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check("idle_after_handshake", {bus.req_ready, bus.busy, bus.res_valid}, 3'b100);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_offset = 2'd0;
      bus.req_target = 8'd0;
      bus.res_ready = 1'b0;
      bus.ex_done = 1'b0;
      bus.ex_state = 3'd0;
      bus.ex_variable = 8'd0;

      // 1: reset release
      repeat (3) step();
      check("in_reset_outputs", {bus.req_ready, bus.busy, bus.ex_start, bus.res_valid, bus.res_timeout}, 5'b10000);
      reset = 1'b1;
      step();
      check("post_reset_outputs", {bus.req_ready, bus.busy, bus.ex_start, bus.res_valid}, 4'b1000);
      check("post_reset_ex_regs", {bus.ex_offset, bus.ex_target}, 10'd0);

      // 2: single command, done 5 cycles after start falls
      send_cmd(2'd2, 8'd120);
      finish_cmd(5, 8'd122, 3'd3);
      check("ex_hold_cmd1", {bus.ex_offset, bus.ex_target}, {2'd2, 8'd120});

      // 3: back-pressure, then simultaneous release and new request
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold", {bus.res_valid, bus.req_ready, bus.res_variable, bus.res_state},
               {1'b1, 1'b0, 8'd122, 3'd3});
      end
      bus.ex_done = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_offset = 2'd1;
      bus.req_target = 8'd50;
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
      check("no_accept_in_result", {bus.req_ready, bus.busy, bus.ex_start, bus.res_valid}, 4'b1000);
      check("ex_hold_after_result", {bus.ex_offset, bus.ex_target}, {2'd2, 8'd120});

      // 4: stale done level on WAIT entry
      bus.ex_done = 1'b1;
      bus.ex_variable = 8'd40;
      bus.ex_state = 3'd1;
      send_cmd(2'd1, 8'd50);
      repeat (3) step();
      check("stale_done_ignored", 32'(bus.res_valid), 0);
      bus.ex_done = 1'b0;
      finish_cmd(2, 8'd51, 3'd5);
      accept_result();
      bus.ex_done = 1'b0;

`ifdef EXAMPLE_DRIVER_TIMEOUT_EN
      // 5: watchdog fires 20 cycles after start falls
      bus.ex_variable = 8'd77;
      bus.ex_state = 3'd6;
      send_cmd(2'd3, 8'd200);
      repeat (19) step();
      check("no_result_before_timeout", 32'(bus.res_valid), 0);
      step();
      check("timeout_result", {bus.res_valid, bus.res_timeout, bus.res_variable, bus.res_state},
            {1'b1, 1'b1, 8'd77, 3'd6});
      check("ex_hold_timeout", {bus.ex_offset, bus.ex_target}, {2'd3, 8'd200});
      accept_result();
      send_cmd(2'd0, 8'd10);
      finish_cmd(2, 8'd10, 3'd4);
      accept_result();
      bus.ex_done = 1'b0;
`else
      // 5: without the watchdog WAIT holds until done finally rises
      send_cmd(2'd3, 8'd200);
      repeat (30) step();
      check("wait_indefinite", {bus.res_valid, bus.busy}, 2'b01);
      finish_cmd(1, 8'd203, 3'd4);
      accept_result();
      bus.ex_done = 1'b0;
`endif

      // 6: reset mid-WAIT
      send_cmd(2'd2, 8'd9);
      repeat (2) step();
      reset = 1'b0;
      #1;
      check("async_reset_outputs", {bus.req_ready, bus.busy, bus.ex_start, bus.res_valid}, 4'b1000);
      check("async_reset_ex_regs", {bus.ex_offset, bus.ex_target}, 10'd0);
      step();
      reset = 1'b1;
      bus.ex_done = 1'b1;
      bus.ex_variable = 8'd99;
      repeat (4) step();
      check("orphan_done_ignored", {bus.res_valid, bus.busy, bus.req_ready}, 3'b001);
      bus.ex_done = 1'b0;
      step();
      send_cmd(2'd1, 8'd30);
      finish_cmd(3, 8'd31, 3'd2);
      accept_result();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
